muldiv_seq_ctrl: RTL and testbench
==================================

Name: muldiv_seq_ctrl

Overview:
- Multi-cycle sequencer for RV64M multiply/divide/remainder ops. The Exec stage's single-cycle ALU does not handle these ops; this block executes them instead.
- Sits beside the Exec stage:
  - Accepts an op when the decoder flags mul/div/rem.
  - Holds the pipeline while iterating.
  - Returns one result with a one-cycle done pulse.
- Uses a radix-2 shift-add multiplier and a restoring divider on a shared 2*WIDTH accumulator. Sign handling is done by pre/post negation.

Parameters:
- WIDTH, 64, datapath width. Only 64 is supported; W-ops use the low 32 bits.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request; decoder drives is_mul|is_div|is_rem.
- op_i  input  3  RV funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- is_W_i  input  1  32-bit W variant (MULW/DIVW/DIVUW/REMW/REMUW); only legal with op_i in {000,100,101,110,111}.
- op1_i  input  WIDTH  rs1 value.
- op2_i  input  WIDTH  rs2 value.
- flush_i  input  1  abort the in-flight op (branch redirect).
- hold_o  output  1  pipeline hold request.
- done_o  output  1  result valid, one-cycle pulse.
- result_o  output  WIDTH  result; held stable until the next done_o.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; counter, accumulator and latched operands cleared.
  - done_o=0, result_o=0, hold_o=0.
  - Applies mid-operation too: the in-flight op is discarded with no done.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - When start_i=1 and flush_i=0, latch op_i, is_W_i and the operands.
  - For W ops, operands are first reduced to their low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Record the result sign and load |operand| magnitudes:
    - Signed: MULH, DIV, REM, MULW, DIVW, REMW.
    - MULHSU: op1 signed, op2 unsigned.
  - Special-case divide:
    - Divisor==0: quotient=all ones, remainder=dividend (W: 32-bit values, then sign-extended).
    - Signed overflow (dividend=most negative, divisor=-1): quotient=dividend, remainder=0.
    - In both cases go directly to DONE.
  - Otherwise go to CALC with counter=N, where N=32 if is_W_i else 64.
- start_i while not IDLE is ignored. The issuer must keep the op stalled under hold_o.
- CALC:
  - One iteration per cycle; decrement the counter; go to FIXUP when the counter reaches 0.
  - Multiply: conditional add of the multiplicand, then shift right, on a 2*WIDTH product.
  - Divide: shift left, trial-subtract the divisor, set the quotient bit if no borrow.
- FIXUP (1 cycle):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Negate the product if the sign flag is set.
  - Select the output:
    - MUL: low WIDTH of product.
    - MULH/MULHSU/MULHU: high WIDTH of product.
    - W ops: low 32 bits sign-extended to 64 (including DIVUW/REMUW).
  - Register the selection into result_o; go to DONE.
- DONE (1 cycle): done_o=1, then go to IDLE. A new start is accepted in the following IDLE cycle.
- hold_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIXUP.
  - Combinational, so the op is held from its first cycle.
  - hold_o=0 in DONE, so the pipeline advances with result_o.
- Latency, counted from the start cycle = cycle 0:
  - Normal ops: done_o in cycle N+2 (66 for 64-bit ops, 34 for W ops).
  - Special-case divide: done_o in cycle 1.
- flush_i=1 in any state:
  - Next state is IDLE; no done_o for the aborted op; result_o unchanged.
  - A simultaneous start_i is ignored.
  - flush_i in DONE suppresses nothing: done_o is already asserted that cycle.
- result_o updates only on entry to DONE.

Test Plan:
- MUL 3 * 0xFFFF_FFFF_FFFF_FFFE (−2) at cycle 0 -> hold_o=1 in cycles 0..65; done_o only in cycle 66; result_o=0xFFFF_FFFF_FFFF_FFFA.
- MULHU 0xFFFF_FFFF_FFFF_FFFF * 0xFFFF_FFFF_FFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFE. MULH of the same operands -> 0x0.
- DIVU 7/0 -> done_o in cycle 1, result 0xFFFF_FFFF_FFFF_FFFF. REMU 7/0 -> result 7. DIV 0x8000_0000_0000_0000 / −1 -> 0x8000_0000_0000_0000, done cycle 1. REM of the same -> 0.
- DIVW op1=0x0000_0000_FFFF_FFF9 (−7), op2=2 -> done_o in cycle 34, result 0xFFFF_FFFF_FFFF_FFFD. REMW of the same -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV 100/7 started, flush_i pulsed in cycle 10:
  - -> hold_o=0 from cycle 11, no done_o, result_o unchanged.
  - REM 100/7 started in cycle 12 -> done_o in cycle 78 with result 2.
- rst asserted in cycle 20 of a MUL -> cycle 21: hold_o=0, done_o=0, result_o=0; no done_o ever for that op.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle RV64M multiply/divide/remainder sequencer.
// A radix-2 shift-add multiplier and a restoring divider share one 2*WIDTH
// accumulator. Operands are converted to magnitudes on entry and the sign
// is reapplied in a single fixup cycle before the result is registered.
module muldiv_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             is_W_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             flush_i,
  output logic             hold_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int AW = 2 * WIDTH;
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  // Sign-extend the low half-word to full width (W-op results and operands).
  function automatic logic [WIDTH-1:0] sext_w(input logic [HW-1:0] v);
    return {{(WIDTH-HW){v[HW-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [AW-1:0] neg_aw(input logic neg, input logic [AW-1:0] v);
    return neg ? -v : v;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic             is_w_q;
  logic             a_neg_q, b_neg_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] opb_q;

  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic signed [WIDTH-1:0] a_red, b_red;
  logic [WIDTH-1:0] a_mag, b_mag, min_val, spec_res, opb_init;
  logic             div_zero, div_ovf, special, accept;
  logic [AW-1:0]    acc_init;

  // Entry decode: operand reduction, sign capture, magnitudes, special cases.
  always_comb begin
    a_sgn    = (op_i inside {3'b001, 3'b010, 3'b100, 3'b110}) | (is_W_i & (op_i == 3'b000));
    b_sgn    = (op_i inside {3'b001, 3'b100, 3'b110}) | (is_W_i & (op_i == 3'b000));
    a_red    = is_W_i ? (a_sgn ? sext_w(op1_i[HW-1:0]) : {{HW{1'b0}}, op1_i[HW-1:0]}) : op1_i;
    b_red    = is_W_i ? (b_sgn ? sext_w(op2_i[HW-1:0]) : {{HW{1'b0}}, op2_i[HW-1:0]}) : op2_i;
    a_neg    = a_sgn & a_red[WIDTH-1];
    b_neg    = b_sgn & b_red[WIDTH-1];
    a_mag    = neg_w(a_neg, a_red);
    b_mag    = neg_w(b_neg, b_red);
    min_val  = is_W_i ? sext_w({1'b1, {(HW-1){1'b0}}}) : {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = op_i[2] & (b_red == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (a_red == min_val) & (b_red == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      spec_res = op_i[1] ? (is_W_i ? sext_w(op1_i[HW-1:0]) : op1_i) : '1;
    else
      spec_res = op_i[1] ? '0 : a_red;
    // The divider consumes dividend bits from the top, so W dividends start
    // in the upper half to finish after 32 iterations.
    acc_init = op_i[2] ? {{WIDTH{1'b0}}, (is_W_i ? (a_mag << HW) : a_mag)}
                       : {{WIDTH{1'b0}}, b_mag};
    opb_init = op_i[2] ? b_mag : a_mag;
    accept   = start_i & ~flush_i;
  end

  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [AW-1:0]    acc_step;

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = acc_q[AW-1:WIDTH-1];
    ge       = rem_sh >= {1'b0, opb_q};
    diff     = rem_sh[WIDTH-1:0] - opb_q;
    if (op_q[2])
      acc_step = ge ? {diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[AW-2:0], 1'b0};
    else
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  logic [AW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] quot_s, rem_s, sel, fix_res;

  // Fixup: reapply signs and pick the architectural result.
  always_comb begin
    prod   = is_w_q ? (acc_q >> HW) : acc_q;
    prod_s = neg_aw(a_neg_q ^ b_neg_q, prod);
    quot_s = neg_w(a_neg_q ^ b_neg_q, acc_q[WIDTH-1:0]);
    rem_s  = neg_w(a_neg_q, acc_q[AW-1:WIDTH]);
    case (op_q)
      3'b000:                 sel = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: sel = prod_s[AW-1:WIDTH];
      3'b100, 3'b101:         sel = quot_s;
      default:                sel = rem_s;
    endcase
    fix_res = is_w_q ? sext_w(sel[HW-1:0]) : sel;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    hold_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        hold_o = accept;
        if (accept) state_d = special ? DONE : CALC;
      end
      CALC: begin
        hold_o = 1'b1;
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        hold_o  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State, operand latch, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      is_w_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        op_q    <= op_i;
        is_w_q  <= is_W_i;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        acc_q   <= acc_init;
        opb_q   <= opb_init;
        cnt_q   <= is_W_i ? CW'(HW) : CW'(WIDTH);
        if (special) result_o <= spec_res;
      end else if (state_q == CALC && !flush_i) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CW'(1);
      end else if (state_q == FIXUP && !flush_i) begin
        result_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        is_w;
  logic [63:0] op1, op2;
  logic        flush;
  logic        hold_o, done_o;
  logic [63:0] result_o;

  muldiv_seq_ctrl #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .is_W_i(is_w),
    .op1_i(op1), .op2_i(op2), .flush_i(flush),
    .hold_o(hold_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int nid   = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_res = 64'd0;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result computed directly from the RV64M definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    logic signed [63:0]  sa, sb64;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         ua32, ub32, r32;
    logic [63:0]         r;
    ua32 = a[31:0]; ub32 = b[31:0];
    sa32 = a[31:0]; sb32 = b[31:0];
    sa = a; sb64 = b;
    r = 64'd0; r32 = 32'd0; p = '0;
    if (w) begin
      case (o)
        3'b100: begin
          if (ub32 == 0) r32 = 32'hFFFF_FFFF;
          else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
          else r32 = sa32 / sb32;
        end
        3'b101: begin
          if (ub32 == 0) r32 = 32'hFFFF_FFFF;
          else r32 = ua32 / ub32;
        end
        3'b110: begin
          if (ub32 == 0) r32 = ua32;
          else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = sa32 % sb32;
        end
        3'b111: begin
          if (ub32 == 0) r32 = ua32;
          else r32 = ua32 % ub32;
        end
        default: r32 = ua32 * ub32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'b000: r = a * b;
        3'b001: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
        3'b010: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = p[127:64]; end
        3'b011: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        3'b100: begin
          if (b == 0) r = '1;
          else if (a == MINV && b == '1) r = a;
          else r = sa / sb64;
        end
        3'b101: begin
          if (b == 0) r = '1;
          else r = a / b;
        end
        3'b110: begin
          if (b == 0) r = a;
          else if (a == MINV && b == '1) r = 64'd0;
          else r = sa % sb64;
        end
        default: begin
          if (b == 0) r = a;
          else r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  // Latency: divides by zero and signed overflow finish in one cycle,
  // everything else iterates N times plus fixup and done.
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (o[2]) begin
      if (w) begin
        if (b[31:0] == 32'd0) return 1;
        if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      end else begin
        if (b == 64'd0) return 1;
        if (!o[0] && a == MINV && b == '1) return 1;
      end
    end
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 20));
      2: v = 64'd0;
      3: v = '1;
      4: v = MINV;
      default: v = {$urandom, 32'h8000_0000};
    endcase
    return v;
  endfunction

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.id), result_o, e.res);
        chk($sformatf("latency#%0d", e.id), 64'(cyc), 64'(e.due));
        last_res = e.res;
      end
    end
  end

  // Present one op for a single cycle; optionally register its expectation.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res,
                       input int lat, input bit track);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; is_w = w; op1 = a; op2 = b;
    #1 chk($sformatf("hold_first#%0d", nid), 64'(hold_o), 64'd1);
    if (track) begin
      e.res = exp_res; e.due = cyc + lat; e.id = nid;
      sb.push_back(e);
    end
    nid++;
    @(negedge clk);
    start = 1'b0;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      #2 k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 3'd0; is_w = 1'b0;
    op1 = 64'd0; op2 = 64'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_hold", 64'(hold_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_result", result_o, 64'd0);

    // MUL 3 * -2 with hold window
    issue(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 66, 1'b1);
    ok = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      if (i > 1) @(negedge clk);
      #1 if (!hold_o || done_o) ok = 1'b0;
    end
    chk("mul_hold_window", 64'(ok), 64'd1);
    @(negedge clk);
    #1 chk("hold_in_done", 64'(hold_o), 64'd0);
    wait_done();

    issue(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b1); wait_done();
    issue(3'b001, 1'b0, '1, '1, 64'h0, 66, 1'b1);                   wait_done();
    issue(3'b101, 1'b0, 64'd7, 64'd0, '1, 1, 1'b1);                 wait_done();
    issue(3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 1, 1'b1);              wait_done();
    issue(3'b100, 1'b0, MINV, '1, MINV, 1, 1'b1);                   wait_done();
    issue(3'b110, 1'b0, MINV, '1, 64'd0, 1, 1'b1);                  wait_done();
    issue(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1); wait_done();
    issue(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b1); wait_done();

    // Flush in cycle 10 of DIV 100/7, then REM 100/7 in cycle 12
    issue(3'b100, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_hold", 64'(hold_o), 64'd0);
    chk("flush_result_kept", result_o, last_res);
    issue(3'b110, 1'b0, 64'd100, 64'd7, 64'd2, 66, 1'b1);
    wait_done();

    // Start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; op1 = 64'd5; op2 = 64'd5;
    #1 chk("start_with_flush_hold", 64'(hold_o), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (70) @(negedge clk);

    // Reset in cycle 20 of a MUL
    issue(3'b000, 1'b0, 64'd9, 64'd9, 64'd0, 0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midop_reset_hold", 64'(hold_o), 64'd0);
    chk("midop_reset_done", 64'(done_o), 64'd0);
    chk("midop_reset_result", result_o, 64'd0);
    last_res = 64'd0;
    repeat (70) @(negedge clk);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      if (rw && ro inside {3'b001, 3'b010, 3'b011}) ro = 3'b000;
      ra = pick();
      rb = pick();
      issue(ro, rw, ra, rb, ref_model(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb), 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
